// File: rtl/exec_seq.sv
// exec_seq: multi-cycle execute sequencer in front of an 8-entry,
// two-read/one-write register file. One instruction in flight at a time.
//
// Ports:
//   clock_i        rising-edge clock shared with the register file
//   reset_i        asynchronous active-high reset
//   instr_valid_i  instruction fields valid
//   instr_ready_o  sequencer can accept an instruction
//   op_i           opcode (ADD SUB AND OR XOR SHL SHR MUL)
//   src1_i/src2_i  operand register indices
//   dst_i          result register index
//   z1_i/z2_i      read-port data from the register file
//   addr1_o/addr2_o register file read addresses
//   addr3_o        register file write address
//   wdata_o        register file write data
//   enable_o       register file write enable
//   done_o         one-cycle pulse in the write-back cycle
//   zero_o         last written result was zero
//
// state | meaning
// IDLE  | waiting for an instruction, instr_ready high
// READ  | read addresses driven, operands captured at end of cycle
// EXEC  | compute; MUL iterates N cycles of shift-add
// WB    | write-back to the register file, done pulse
module exec_seq #(
  parameter int N = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         instr_valid_i,
  output logic         instr_ready_o,
  input  logic [2:0]   op_i,
  input  logic [2:0]   src1_i,
  input  logic [2:0]   src2_i,
  input  logic [2:0]   dst_i,
  input  logic [N-1:0] z1_i,
  input  logic [N-1:0] z2_i,
  output logic [2:0]   addr1_o,
  output logic [2:0]   addr2_o,
  output logic [2:0]   addr3_o,
  output logic [N-1:0] wdata_o,
  output logic         enable_o,
  output logic         done_o,
  output logic         zero_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic [2:0]    dst_q;
  logic [N-1:0]  a_q;      // operand A, doubles as multiplicand during MUL
  logic [N-1:0]  b_q;      // operand B, doubles as multiplier during MUL
  logic [N-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    addr1_q;
  logic [2:0]    addr2_q;
  logic [2:0]    addr3_q;
  logic [N-1:0]  wdata_q;
  logic          enable_q;
  logic          done_q;
  logic          zero_q;
  logic          ready_q;

  logic [N-1:0]  acc_d;
  logic [N-1:0]  result_d;

  always_comb begin
    acc_d    = acc_q + (b_q[0] ? a_q : '0);
    result_d = '0;
    case (op_q)
      OP_ADD:  result_d = a_q + b_q;
      OP_SUB:  result_d = a_q - b_q;
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      OP_XOR:  result_d = a_q ^ b_q;
      OP_SHL:  result_d = {a_q[N-2:0], 1'b0};
      OP_SHR:  result_d = {1'b0, a_q[N-1:1]};
      OP_MUL:  result_d = acc_d;   // valid on the final iteration
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      addr3_q  <= '0;
      wdata_q  <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_valid_i && ready_q) begin
            op_q    <= op_i;
            dst_q   <= dst_i;
            addr1_q <= src1_i;
            addr2_q <= src2_i;
            ready_q <= 1'b0;
            state_q <= READ;
          end else begin
            ready_q <= 1'b1;
          end
        end
        READ: begin
          a_q     <= z1_i;
          b_q     <= z2_i;
          acc_q   <= '0;
          cnt_q   <= CW'(N - 1);
          state_q <= EXEC;
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q - CW'(1);
          end
          if (op_q != OP_MUL || cnt_q == '0) begin
            wdata_q  <= result_d;
            addr3_q  <= dst_q;
            enable_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= WB;
          end
        end
        WB: begin
          wdata_q  <= '0;
          addr3_q  <= '0;
          enable_q <= 1'b0;
          done_q   <= 1'b0;
          zero_q   <= (wdata_q == '0);
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready_o = ready_q;
  assign addr1_o       = addr1_q;
  assign addr2_o       = addr2_q;
  assign addr3_o       = addr3_q;
  assign wdata_o       = wdata_q;
  assign enable_o      = enable_q;
  assign done_o        = done_q;
  assign zero_o        = zero_q;

endmodule

// File: tb/tb_exec_seq.sv
module tb_exec_seq;

  logic       clock;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] op, src1, src2, dst;
  logic [7:0] z1, z2;
  logic [2:0] addr1, addr2, addr3;
  logic [7:0] wdata;
  logic       enable, done, zero;

  // register file model with two extra preload ports
  logic [7:0] rf [8];
  logic       pre_we1, pre_we2;
  logic [2:0] pre_a1, pre_a2;
  logic [7:0] pre_d1, pre_d2;

  int checks = 0;
  int errors = 0;

  exec_seq #(.N(8)) dut (
    .clock_i(clock), .reset_i(reset),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .op_i(op), .src1_i(src1), .src2_i(src2), .dst_i(dst),
    .z1_i(z1), .z2_i(z2),
    .addr1_o(addr1), .addr2_o(addr2), .addr3_o(addr3),
    .wdata_o(wdata), .enable_o(enable), .done_o(done), .zero_o(zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign z1 = rf[addr1];
  assign z2 = rf[addr2];

  always @(posedge clock) begin
    if (enable)  rf[addr3]  <= wdata;
    if (pre_we1) rf[pre_a1] <= pre_d1;
    if (pre_we2) rf[pre_a2] <= pre_d2;
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] d;
    logic       pre1;
    logic [7:0] va;
    logic       pre2;
    logic [7:0] vb;
    logic [7:0] exp;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs [14];
  vec_t v;

  time t_prev;
  int  prev_lat;
  bit  have_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after WB.
  task automatic run_vec(input vec_t vv);
    int  lat;
    bit  got;
    time t_acc;
    instr_valid = 1'b1;
    op = vv.op; src1 = vv.s1; src2 = vv.s2; dst = vv.d;
    pre_we1 = vv.pre1; pre_a1 = vv.s1; pre_d1 = vv.va;
    pre_we2 = vv.pre2; pre_a2 = vv.s2; pre_d2 = vv.vb;
    chk("ready_before_accept", instr_ready, 1);
    @(posedge clock);
    t_acc = $time;
    if (have_prev) chk("accept_period", t_acc - t_prev, (prev_lat + 1) * 10);
    t_prev = t_acc; prev_lat = vv.lat; have_prev = 1'b1;
    #1;
    instr_valid = 1'b0; pre_we1 = 1'b0; pre_we2 = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        chk("read_addr1", addr1, vv.s1);
        chk("read_addr2", addr2, vv.s2);
      end
      if (done) got = 1'b1;
      else if (instr_ready) chk("ready_busy", instr_ready, 0);
    end
    chk("wb_latency", lat, vv.lat);
    chk("wb_wdata", wdata, vv.exp);
    chk("wb_addr3", addr3, vv.d);
    chk("wb_enable", enable, 1);
    @(negedge clock);
    chk("zero_flag", zero, vv.z);
    chk("rf_dst", rf[vv.d], vv.exp);
    chk("ready_after_wb", instr_ready, 1);
    chk("enable_idle", enable, 0);
    chk("done_idle", done, 0);
    chk("wdata_idle", wdata, 0);
    chk("addr3_idle", addr3, 0);
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pre_we1 = 1'b1; pre_a1 = a; pre_d1 = d;
    @(posedge clock); #1;
    pre_we1 = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    //            op      s1 s2 d  p1 va     p2 vb     exp    z  lat
    vecs[0]  = '{3'b000, 1, 2, 3, 1, 8'd200, 1, 8'd100, 8'd44,  0, 3};
    vecs[1]  = '{3'b001, 1, 1, 4, 1, 8'd7,   0, 8'd0,   8'd0,   1, 3};
    vecs[2]  = '{3'b011, 4, 2, 5, 0, 8'd0,   1, 8'd9,   8'd9,   0, 3};
    vecs[3]  = '{3'b010, 1, 2, 7, 1, 8'hF0,  1, 8'h3C,  8'h30,  0, 3};
    vecs[4]  = '{3'b100, 1, 2, 7, 1, 8'hAA,  1, 8'hAA,  8'h00,  1, 3};
    vecs[5]  = '{3'b111, 1, 2, 6, 1, 8'd13,  1, 8'd11,  8'd143, 0, 10};
    vecs[6]  = '{3'b111, 1, 2, 6, 1, 8'd16,  1, 8'd16,  8'd0,   1, 10};
    vecs[7]  = '{3'b111, 1, 2, 6, 1, 8'd255, 1, 8'd255, 8'h01,  0, 10};
    vecs[8]  = '{3'b101, 1, 1, 1, 1, 8'h81,  0, 8'h00,  8'h02,  0, 3};
    vecs[9]  = '{3'b110, 1, 0, 2, 0, 8'h00,  0, 8'h00,  8'h01,  0, 3};
    vecs[10] = '{3'b000, 2, 2, 2, 0, 8'h00,  0, 8'h00,  8'h02,  0, 3};
    vecs[11] = '{3'b001, 3, 4, 0, 1, 8'd5,   1, 8'd6,   8'hFF,  0, 3};
    vecs[12] = '{3'b110, 3, 3, 1, 1, 8'h80,  0, 8'h00,  8'h40,  0, 3};
    vecs[13] = '{3'b101, 3, 3, 1, 1, 8'h80,  0, 8'h00,  8'h00,  1, 3};

    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    reset = 1'b1; instr_valid = 1'b0;
    op = '0; src1 = '0; src2 = '0; dst = '0;
    pre_we1 = 1'b0; pre_we2 = 1'b0; pre_a1 = '0; pre_a2 = '0; pre_d1 = '0; pre_d2 = '0;
    have_prev = 1'b0; t_prev = 0; prev_lat = 0;

    @(negedge clock);
    chk("rst_ready", instr_ready, 0);
    chk("rst_enable", enable, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_addr1", addr1, 0);
    chk("rst_addr2", addr2, 0);
    chk("rst_addr3", addr3, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", instr_ready, 1);

    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      run_vec(v);
    end

    // Handshake: valid stays high with other fields while busy.
    have_prev = 1'b0;
    preload(3'd7, 8'h55);
    begin
      int extra;
      instr_valid = 1'b1; op = 3'b000; src1 = 1; src2 = 2; dst = 3;
      pre_we1 = 1'b1; pre_a1 = 1; pre_d1 = 8'd1;
      pre_we2 = 1'b1; pre_a2 = 2; pre_d2 = 8'd2;
      @(posedge clock); #1;
      pre_we1 = 1'b0; pre_we2 = 1'b0;
      op = 3'b001; src1 = 4; src2 = 5; dst = 7;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clock);
        chk("hs_ready_low", instr_ready, 0);
      end
      chk("hs_done", done, 1);
      chk("hs_wdata", wdata, 8'd3);
      chk("hs_addr3", addr3, 3);
      @(negedge clock);
      instr_valid = 1'b0;
      chk("hs_ready_back", instr_ready, 1);
      extra = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clock);
        if (done || enable) extra++;
      end
      chk("hs_no_second_exec", extra, 0);
      chk("hs_r7_kept", rf[7], 8'h55);
      chk("hs_r3", rf[3], 8'd3);
    end

    // Reset in the 4th EXEC cycle of a MUL.
    preload(3'd6, 8'h77);
    instr_valid = 1'b1; op = 3'b111; src1 = 1; src2 = 2; dst = 6;
    pre_we1 = 1'b1; pre_a1 = 1; pre_d1 = 8'd3;
    pre_we2 = 1'b1; pre_a2 = 2; pre_d2 = 8'd5;
    @(posedge clock); #1;
    instr_valid = 1'b0; pre_we1 = 1'b0; pre_we2 = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_mid_enable", enable, 0);
    chk("rst_mid_ready", instr_ready, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_addr1", addr1, 0);
    @(posedge clock);
    @(negedge clock);
    chk("rst_mid_ready_held", instr_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_ready_after", instr_ready, 1);
    chk("rst_mid_r6_kept", rf[6], 8'h77);
    chk("rst_mid_zero", zero, 0);
    v = '{3'b000, 1, 2, 3, 1, 8'd10, 1, 8'd20, 8'd30, 0, 3};
    run_vec(v);
    chk("rst_mid_r6_final", rf[6], 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
